alu_core_p: RTL

Parametrised successor to the datapath ALU. Holds two operand registers (A, B) loaded from the immediate bus or the RAM read bus. Executes single-cycle arithmetic and logic ops plus a multi-cycle shift-add multiply, and drives a registered result with status flags. Sits between the instruction decoder (4-bit opcode) and the RAM/output path; the decoder uses busy/done to stall during multiply.

---
 rtl/alu_core_p.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/alu_core_p.sv
// alu_core_p: two-operand datapath ALU with registered result/flags and a
// multi-cycle unsigned shift-add multiplier. The decoder stalls on busy.
module alu_core_p #(
  parameter  int WIDTH = 8,
  localparam int SH_W  = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] ram_in,
  input  logic [3:0]       inst,
  output logic [WIDTH-1:0] rtn,
  output logic [WIDTH-1:0] rtn_hi,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] OP_LDA_D = 4'h3;
  localparam logic [3:0] OP_LDB_D = 4'h4;
  localparam logic [3:0] OP_LDA_R = 4'h5;
  localparam logic [3:0] OP_LDB_R = 4'h6;
  localparam logic [3:0] OP_ADD   = 4'h7;
  localparam logic [3:0] OP_SUB   = 4'h8;
  localparam logic [3:0] OP_AND   = 4'h9;
  localparam logic [3:0] OP_OR    = 4'hA;
  localparam logic [3:0] OP_XOR   = 4'hB;
  localparam logic [3:0] OP_SHL   = 4'hC;
  localparam logic [3:0] OP_SHR   = 4'hD;
  localparam logic [3:0] OP_MUL   = 4'hE;
  localparam logic [3:0] OP_CMP   = 4'hF;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]     rtn_q, rtn_d, rtn_hi_q, rtn_hi_d;
  logic [3:0]           flags_q, flags_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   ma_q, ma_d, acc_q, acc_d;
  logic [WIDTH-1:0]     mb_q, mb_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [WIDTH:0]       sum_w, diff_w, shl_w, shr_w;
  logic [2*WIDTH-1:0]   acc_step;
  logic [SH_W-1:0]      sh_amt;

  // Signed overflow of a+b: operands agree in sign but the result does not.
  function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] r);
    return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  // Signed overflow of a-b: operands differ in sign and result flips from a.
  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] r);
    return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  // Datapath results; one extra bit carries carry/borrow/shifted-out bit.
  always_comb begin
    sh_amt   = b_q[SH_W-1:0];
    sum_w    = {1'b0, a_q} + {1'b0, b_q};
    diff_w   = {1'b0, a_q} - {1'b0, b_q};
    shl_w    = {1'b0, a_q} << sh_amt;
    shr_w    = {a_q, 1'b0} >> sh_amt;
    acc_step = acc_q + (mb_q[0] ? ma_q : '0);
  end

  // Next-state: opcode decode in IDLE, one shift-add step per edge in RUN.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    rtn_d    = rtn_q;
    rtn_hi_d = rtn_hi_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    ma_d     = ma_q;
    mb_d     = mb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        case (inst)
          OP_LDA_D: a_d = data_in;
          OP_LDB_D: b_d = data_in;
          OP_LDA_R: a_d = ram_in;
          OP_LDB_R: b_d = ram_in;
          OP_ADD: begin
            rtn_d    = sum_w[WIDTH-1:0];
            rtn_hi_d = '0;
            flags_d  = {sum_w[WIDTH-1], sum_w[WIDTH-1:0] == '0, sum_w[WIDTH],
                        add_ovf(a_q, b_q, sum_w[WIDTH-1:0])};
            done_d   = 1'b1;
          end
          OP_SUB, OP_CMP: begin
            if (inst == OP_SUB) begin
              rtn_d    = diff_w[WIDTH-1:0];
              rtn_hi_d = '0;
            end
            flags_d = {diff_w[WIDTH-1], diff_w[WIDTH-1:0] == '0, diff_w[WIDTH],
                       sub_ovf(a_q, b_q, diff_w[WIDTH-1:0])};
            done_d  = 1'b1;
          end
          OP_AND, OP_OR, OP_XOR: begin
            if (inst == OP_AND)      rtn_d = a_q & b_q;
            else if (inst == OP_OR)  rtn_d = a_q | b_q;
            else                     rtn_d = a_q ^ b_q;
            rtn_hi_d = '0;
            flags_d  = {rtn_d[WIDTH-1], rtn_d == '0, 2'b00};
            done_d   = 1'b1;
          end
          OP_SHL: begin
            rtn_d    = shl_w[WIDTH-1:0];
            rtn_hi_d = '0;
            flags_d  = {shl_w[WIDTH-1], shl_w[WIDTH-1:0] == '0, shl_w[WIDTH], 1'b0};
            done_d   = 1'b1;
          end
          OP_SHR: begin
            rtn_d    = shr_w[WIDTH:1];
            rtn_hi_d = '0;
            flags_d  = {shr_w[WIDTH], shr_w[WIDTH:1] == '0, shr_w[0], 1'b0};
            done_d   = 1'b1;
          end
          OP_MUL: begin
            ma_d    = {{WIDTH{1'b0}}, a_q};
            mb_d    = b_q;
            acc_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
            state_d = RUN;
          end
          default: ;
        endcase
      end
      RUN: begin
        acc_d = acc_step;
        ma_d  = ma_q << 1;
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rtn_d    = acc_step[WIDTH-1:0];
          rtn_hi_d = acc_step[2*WIDTH-1:WIDTH];
          flags_d  = {acc_step[WIDTH-1], acc_step == '0,
                      acc_step[2*WIDTH-1:WIDTH] != '0,
                      acc_step[2*WIDTH-1:WIDTH] != '0};
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset clears everything and aborts any multiply.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      rtn_q    <= '0;
      rtn_hi_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      ma_q     <= '0;
      mb_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rtn_q    <= rtn_d;
      rtn_hi_q <= rtn_hi_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rtn    = rtn_q;
  assign rtn_hi = rtn_hi_q;
  assign flags  = flags_q;
  assign busy   = (state_q == RUN);
  assign done   = done_q;

endmodule
